// File: rtl/timed_traffic_ctrl.sv
// Highway / country-road crossing controller.
// Six-state Moore machine with a shared dwell timer. The highway rests on
// green and yields to the country road only after a minimum green time. The
// country road keeps green while cars are present, up to a maximum dwell.
// Lamp outputs and the timeout pulse are registered and depend only on the
// state, so the sensor input never reaches the lamps combinationally.
module timed_traffic_ctrl #(
  parameter int MIN_GREEN  = 8,
  parameter int Y2R_DELAY  = 4,
  parameter int R2G_DELAY  = 2,
  parameter int MAX_CGREEN = 16,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       X,
  output logic [1:0] highway,
  output logic [1:0] country,
  output logic [2:0] state,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S0 = 3'd0,  // highway green, country red
    S1 = 3'd1,  // highway yellow, country red
    S2 = 3'd2,  // all red, clearing toward the country road
    S3 = 3'd3,  // highway red, country green
    S4 = 3'd4,  // highway red, country yellow
    S5 = 3'd5   // all red, clearing back toward the highway
  } state_e;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  // Last timer value of each dwell; the state changes on the edge that ends it.
  localparam logic [CNT_W-1:0] MIN_GREEN_LAST  = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] Y2R_LAST        = CNT_W'(Y2R_DELAY - 1);
  localparam logic [CNT_W-1:0] R2G_LAST        = CNT_W'(R2G_DELAY - 1);
  localparam logic [CNT_W-1:0] MAX_CGREEN_LAST = CNT_W'(MAX_CGREEN - 1);

  // The state register is kept as a plain 3-bit vector so that the unused
  // codes 6 and 7 are ordinary values that the next-state logic recovers from.
  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [CNT_W-1:0] tmr_q;
  logic [CNT_W-1:0] tmr_d;
  logic             timeout_q;
  logic             timeout_d;
  logic [1:0]       highway_q;
  logic [1:0]       highway_d;
  logic [1:0]       country_q;
  logic [1:0]       country_d;

  // Next state, next dwell count and timeout flag from the current state, timer and sensor.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q + CNT_W'(1);
    timeout_d = 1'b0;
    case (state_q)
      S0: begin
        if (tmr_q >= MIN_GREEN_LAST) begin
          if (X) begin
            state_d = S1;
            tmr_d   = '0;
          end else begin
            tmr_d = MIN_GREEN_LAST;
          end
        end
      end
      S1: begin
        if (tmr_q >= Y2R_LAST) begin
          state_d = S2;
          tmr_d   = '0;
        end
      end
      S2: begin
        if (tmr_q >= R2G_LAST) begin
          state_d = S3;
          tmr_d   = '0;
        end
      end
      S3: begin
        if (!X) begin
          state_d = S4;
          tmr_d   = '0;
        end else if (tmr_q >= MAX_CGREEN_LAST) begin
          state_d   = S4;
          tmr_d     = '0;
          timeout_d = 1'b1;
        end
      end
      S4: begin
        if (tmr_q >= Y2R_LAST) begin
          state_d = S5;
          tmr_d   = '0;
        end
      end
      S5: begin
        if (tmr_q >= R2G_LAST) begin
          state_d = S0;
          tmr_d   = '0;
        end
      end
      default: begin
        state_d = S0;
        tmr_d   = '0;
      end
    endcase
  end

  // Lamp decode of the upcoming state; any unknown code shows red on both roads.
  always_comb begin
    highway_d = RED;
    country_d = RED;
    case (state_d)
      S0:      highway_d = GREEN;
      S1:      highway_d = YELLOW;
      S3:      country_d = GREEN;
      S4:      country_d = YELLOW;
      default: begin
        highway_d = RED;
        country_d = RED;
      end
    endcase
  end

  // Machine registers; clear forces highway green at once, skipping any yellow.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q   <= S0;
      tmr_q     <= '0;
      timeout_q <= 1'b0;
      highway_q <= GREEN;
      country_q <= RED;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      timeout_q <= timeout_d;
      highway_q <= highway_d;
      country_q <= country_d;
    end
  end

  assign state   = state_q;
  assign highway = highway_q;
  assign country = country_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_timed_traffic_ctrl.sv
// Directed bench for timed_traffic_ctrl with short dwell parameters.
// Per-cycle expectations come from a table of segments; the asynchronous
// clear, sensor glitch and illegal-state cases are written out by hand.
module tb_timed_traffic_ctrl;

  localparam int MIN_GREEN  = 4;
  localparam int Y2R_DELAY  = 3;
  localparam int R2G_DELAY  = 2;
  localparam int MAX_CGREEN = 6;
  localparam int CNT_W      = 8;

  logic       clk;
  logic       clear;
  logic       X;
  logic [1:0] highway;
  logic [1:0] country;
  logic [2:0] state;
  logic       timeout;

  int testsRun;
  int failCount;

  typedef struct {
    bit         rst;
    bit         x;
    logic [2:0] st;
    bit         to;
  } vec_t;

  vec_t vecs[$];

  timed_traffic_ctrl #(
    .MIN_GREEN (MIN_GREEN),
    .Y2R_DELAY (Y2R_DELAY),
    .R2G_DELAY (R2G_DELAY),
    .MAX_CGREEN(MAX_CGREEN),
    .CNT_W     (CNT_W)
  ) dut (
    .clk    (clk),
    .clear  (clear),
    .X      (X),
    .highway(highway),
    .country(country),
    .state  (state),
    .timeout(timeout)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case anything stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Lamp colours expected for each state code.
  function automatic logic [1:0] expHw(logic [2:0] s);
    if (s == 3'd0) return 2'd2;
    if (s == 3'd1) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [1:0] expCty(logic [2:0] s);
    if (s == 3'd3) return 2'd2;
    if (s == 3'd4) return 2'd1;
    return 2'd0;
  endfunction

  // Append n cycles of one state; reset and timeout apply to the first only.
  task automatic addSeg(bit rst, bit x, logic [2:0] st, int n, bit toFirst);
    vec_t v;
    for (int k = 0; k < n; k++) begin
      v.rst = rst && (k == 0);
      v.x   = x;
      v.st  = st;
      v.to  = toFirst && (k == 0);
      vecs.push_back(v);
    end
  endtask

  task automatic applyStimulus(bit xVal);
    X = xVal;
    #1;
  endtask

  task automatic checkOutput(string name, logic [2:0] expSt, bit expTo);
    logic [7:0] act;
    logic [7:0] exp;
    act = {state, highway, country, timeout};
    exp = {expSt, expHw(expSt), expCty(expSt), expTo};
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got state=%0d hw=%0d cty=%0d to=%0d, expected state=%0d hw=%0d cty=%0d to=%0d",
               name, state, highway, country, timeout, expSt, expHw(expSt), expCty(expSt), expTo);
    end
  endtask

  task automatic checkTmr(string name, logic [CNT_W-1:0] expTmr);
    testsRun++;
    if (dut.tmr_q !== expTmr) begin
      failCount++;
      $display("[TB] FAIL %s: got tmr=%0d, expected tmr=%0d", name, dut.tmr_q, expTmr);
    end
  endtask

  // Hold clear across two falling edges, then release on a falling edge.
  task automatic doReset();
    clear = 1'b1;
    X     = 1'b0;
    #1;
    checkOutput("resetState", 3'd0, 1'b0);
    checkTmr("resetTmr", '0);
    @(negedge clk);
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic waitForState(string name, logic [2:0] target, int budget);
    int n;
    n = 0;
    while (state !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    testsRun++;
    if (state !== target) begin
      failCount++;
      $display("[TB] FAIL %s: got state=%0d after %0d cycles, expected state=%0d", name, state, n, target);
    end
  endtask

  initial begin
    testsRun  = 0;
    failCount = 0;
    clear     = 1'b1;
    X         = 1'b0;

    // Idle with no country traffic: highway stays green.
    addSeg(1, 0, 3'd0, 20, 0);

    // One-cycle request while the minimum green is still running is ignored.
    addSeg(1, 0, 3'd0, 1, 0);
    addSeg(0, 1, 3'd0, 1, 0);
    addSeg(0, 0, 3'd0, 8, 0);

    // Continuous traffic: full cycle with the country green cut by timeout.
    addSeg(1, 1, 3'd0, 4, 0);
    addSeg(0, 1, 3'd1, 3, 0);
    addSeg(0, 1, 3'd2, 2, 0);
    addSeg(0, 1, 3'd3, 6, 0);
    addSeg(0, 1, 3'd4, 3, 1);
    addSeg(0, 1, 3'd5, 2, 0);
    addSeg(0, 1, 3'd0, 4, 0);
    addSeg(0, 1, 3'd1, 1, 0);

    // Country road empties two cycles into its green: no timeout.
    addSeg(1, 1, 3'd0, 4, 0);
    addSeg(0, 1, 3'd1, 3, 0);
    addSeg(0, 1, 3'd2, 2, 0);
    addSeg(0, 1, 3'd3, 2, 0);
    addSeg(0, 0, 3'd3, 1, 0);
    addSeg(0, 0, 3'd4, 3, 0);
    addSeg(0, 0, 3'd5, 2, 0);
    addSeg(0, 0, 3'd0, 3, 0);

    // Car leaves during highway yellow: sequence completes, country green lasts one cycle.
    addSeg(1, 1, 3'd0, 4, 0);
    addSeg(0, 0, 3'd1, 3, 0);
    addSeg(0, 0, 3'd2, 2, 0);
    addSeg(0, 0, 3'd3, 1, 0);
    addSeg(0, 0, 3'd4, 3, 0);
    addSeg(0, 0, 3'd5, 2, 0);
    addSeg(0, 0, 3'd0, 2, 0);

    // Late arrival after a long idle: saturated timer yields on the next edge.
    addSeg(1, 0, 3'd0, 7, 0);
    addSeg(0, 1, 3'd0, 1, 0);
    addSeg(0, 1, 3'd1, 1, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) doReset();
      applyStimulus(vecs[i].x);
      checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].to);
      @(negedge clk);
    end

    // Sensor pulse between edges must not be seen.
    doReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0);
      @(negedge clk);
    end
    X = 1'b1;
    #2;
    X = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("glitchIgnored", 3'd0, 1'b0);
    X = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("realRequest", 3'd1, 1'b0);

    // Asynchronous clear in the middle of country green.
    doReset();
    X = 1'b1;
    waitForState("reachS3", 3'd3, 30);
    @(negedge clk);
    #2;
    clear = 1'b1;
    #1;
    checkOutput("clearMidS3", 3'd0, 1'b0);
    checkTmr("clearMidS3Tmr", '0);
    @(negedge clk);
    #1;
    checkOutput("clearHeld", 3'd0, 1'b0);
    @(negedge clk);
    clear = 1'b0;
    #1;
    checkOutput("afterClearFirst", 3'd0, 1'b0);
    checkTmr("afterClearTmr", '0);
    @(negedge clk);
    #1;
    checkOutput("afterClearNoYellow", 3'd0, 1'b0);
    checkTmr("afterClearCount", 8'd1);

    // Clear during the timeout pulse drops it at once.
    waitForState("reachS4", 3'd4, 40);
    #1;
    checkOutput("timeoutPulse", 3'd4, 1'b1);
    clear = 1'b1;
    #1;
    checkOutput("timeoutCleared", 3'd0, 1'b0);
    @(negedge clk);
    clear = 1'b0;

    // Unused state code recovers to S0 with a fresh timer.
    doReset();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0);
      @(negedge clk);
    end
    force dut.state_q = 3'd6;
    #1;
    release dut.state_q;
    @(negedge clk);
    #1;
    checkOutput("illegalRecover", 3'd0, 1'b0);
    checkTmr("illegalRecoverTmr", '0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/timed_traffic_ctrl.md
TIMED_TRAFFIC_CTRL -- requirements
Module: timed_traffic_ctrl

Interface
REQ-001 SHALL have parameter MIN_GREEN, 8, minimum highway-green dwell in cycles (>=1).
REQ-002 SHALL have parameter Y2R_DELAY, 4, yellow dwell in cycles (>=1).
REQ-003 SHALL have parameter R2G_DELAY, 2, all-red clearance dwell in cycles (>=1).
REQ-004 SHALL have parameter MAX_CGREEN, 16, maximum country-green dwell in cycles (>=1).
REQ-005 SHALL have parameter CNT_W, 8, dwell-timer width; every delay parameter SHALL fit in CNT_W bits.
REQ-006 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-007 SHALL have port clear  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port X  input  1  country-road car sensor; 1 = car waiting or present.
REQ-009 SHALL have port highway  output  2  highway signal: RED=2'd0, YELLOW=2'd1, GREEN=2'd2.
REQ-010 SHALL have port country  output  2  country signal, same encoding.
REQ-011 SHALL have port state  output  3  current state code S0..S5.
REQ-012 SHALL have port timeout  output  1  one-cycle pulse when country green is ended by MAX_CGREEN.

Function
REQ-013 SHALL implement a Moore FSM with six states: S0=0 HG/CR, S1=1 HY/CR, S2=2 HR/CR, S3=3 HR/CG, S4=4 HR/CY, S5=5 HR/CR (return clearance).
REQ-014 highway and country SHALL decode from the state register only, with no dependence on X.
REQ-015 Dwell timer tmr SHALL be 0 in the first cycle of every state and SHALL increment by 1 each cycle the state is held.
REQ-016 In S0, tmr SHALL saturate at MIN_GREEN-1 and SHALL NOT wrap.
REQ-017 S0->S1 SHALL occur when X==1 and tmr==MIN_GREEN-1, so highway green lasts >= MIN_GREEN cycles.
REQ-018 S1->S2 SHALL occur after exactly Y2R_DELAY cycles in S1.
REQ-019 S2->S3 SHALL occur after exactly R2G_DELAY cycles in S2.
REQ-020 S3->S4 SHALL occur when X==0, or when tmr==MAX_CGREEN-1; X==0 SHALL take priority if both hold.
REQ-021 S4->S5 SHALL occur after exactly Y2R_DELAY cycles in S4.
REQ-022 S5->S0 SHALL occur after exactly R2G_DELAY cycles in S5.
REQ-023 timeout SHALL be registered and assert for exactly the first S4 cycle when S3 exited via MAX_CGREEN with X==1; otherwise 0.
REQ-024 X SHALL be sampled only at the clock edge; a glitch between edges SHALL have no effect.
REQ-025 If X drops in S1 or S2, the sequence SHALL still complete through S3, which then exits after its first cycle because X==0.
REQ-026 Unused state codes 6 and 7 SHALL transition to S0 with tmr=0 on the next edge.
REQ-027 No state SHALL ever drive both roads non-RED simultaneously.

Reset
REQ-028 clear==1 SHALL immediately, without a clock edge, force state=S0, tmr=0, highway=GREEN, country=RED, timeout=0.
REQ-029 While clear is held, the block SHALL stay in S0. After release, the first edge SHALL begin S0 dwell counting from tmr=0.
REQ-030 clear asserted mid-sequence, in any state, SHALL abort that sequence with no yellow phase.

Verification (MIN_GREEN=4, Y2R_DELAY=3, R2G_DELAY=2, MAX_CGREEN=6)
REQ-031 Release clear with X=0 for 20 cycles -> state stays S0, highway=2, country=0, timeout=0 throughout.
REQ-032 Release clear with X=1 held -> S0 for 4 cycles, S1 for 3, S2 for 2, S3 for 6, then S4 with timeout=1 in its first cycle only, S4 for 3 cycles, S5 for 2, then S0 for 4 more cycles before S1.
REQ-033 X=1 until 2 cycles into S3, then X=0 -> S3 lasts 3 cycles, S4 follows, timeout stays 0.
REQ-034 X=1 for one cycle at S0 tmr=1, then X=0 -> no transition; state stays S0.
REQ-035 Assert clear asynchronously mid-S3 -> outputs go to highway=2, country=0, state=0 before the next clk edge.
REQ-036 Force an illegal state code via bench -> next edge gives state=0, tmr=0.
